// File: rtl/bridge_pkg.sv
// bridge_pkg: APB FSM state encoding, peripheral slot map and address decode
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RENABLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WRITEP,
        ST_WENABLE,
        ST_WENABLEP
    } state_e;

    localparam logic [31:0] SLOT0_BASE = 32'h8000_0000;
    localparam logic [31:0] SLOT1_BASE = 32'h8400_0000;
    localparam logic [31:0] SLOT2_BASE = 32'h8800_0000;
    localparam logic [31:0] SLOT_LIMIT = 32'h8C00_0000;

    // Half-open slot ranges; anything outside selects no peripheral.
    function automatic logic [2:0] decode_sel(input logic [31:0] addr);
        return (addr >= SLOT0_BASE && addr < SLOT1_BASE) ? 3'b001 :
               (addr >= SLOT1_BASE && addr < SLOT2_BASE) ? 3'b010 :
               (addr >= SLOT2_BASE && addr < SLOT_LIMIT) ? 3'b100 : 3'b000;
    endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: sequences APB SETUP/ACCESS phases from the pipelined AHB beat
module apb_fsm_controller
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwrite_reg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr1,
    input  logic [ADDR_W-1:0] haddr2,
    input  logic [ADDR_W-1:0] hwdata,
    input  logic [ADDR_W-1:0] hwdata1,
    input  logic [ADDR_W-1:0] pr_data,
    output logic [2:0]        pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [ADDR_W-1:0] pwdata,
    output logic              hreadyout
);

    state_e state_q, state_d;
    state_e dispatch;
    logic   unused_rdata;

    assign unused_rdata = ^pr_data;
    assign dispatch = !valid ? ST_IDLE : hwrite ? ST_WWAIT : ST_READ;

    // Next state: IDLE and both ENABLE-exits reuse the dispatch decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: state_d = dispatch;
            ST_READ:     state_d = ST_RENABLE;
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_WENABLEP: state_d = !hwrite_reg ? ST_READ : valid ? ST_WRITEP : ST_WRITE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State and APB outputs, loaded on entry to the next state.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= ST_IDLE;
            pselx     <= 3'b000;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            hreadyout <= 1'b1;
        end else begin
            state_q   <= state_d;
            hreadyout <= !(state_d == ST_READ || state_d == ST_WRITEP);
            case (state_d)
                ST_READ, ST_WRITE, ST_WRITEP: begin
                    penable <= 1'b0;
                    pwrite  <= state_d != ST_READ;
                    if (state_q == ST_WENABLEP) begin
                        paddr  <= haddr2;
                        pwdata <= hwdata1;
                        pselx  <= decode_sel(haddr2);
                    end else if (state_d == ST_READ) begin
                        paddr <= haddr;
                        pselx <= decode_sel(haddr);
                    end else begin
                        paddr  <= haddr1;
                        pwdata <= hwdata;
                        pselx  <= decode_sel(haddr1);
                    end
                end
                ST_RENABLE, ST_WENABLE, ST_WENABLEP: penable <= 1'b1;
                default: begin
                    pselx   <= 3'b000;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule
